// File: rtl/mm_digit_serial_mac_if.sv
// Operand/result handshake plus the multiplier-side port bundle of the
// digit-serial MAC controller.
interface mm_digit_serial_mac_if #(
  parameter int A_W     = 149,
  parameter int D_W     = 16,
  parameter int NUM_DIG = 9
);
  logic                       start;
  logic [A_W-1:0]             a_in;
  logic [NUM_DIG*D_W-1:0]     b_in;
  logic                       busy;
  logic [A_W-1:0]             mult_a;
  logic [D_W-1:0]             mult_b;
  logic [A_W+D_W-1:0]         mult_p;
  logic                       done;
  logic [A_W+NUM_DIG*D_W-1:0] result;

  modport slave (
    input  start, a_in, b_in, mult_p,
    output busy, mult_a, mult_b, done, result
  );

  modport master (
    output start, a_in, b_in, mult_p,
    input  busy, mult_a, mult_b, done, result
  );
endinterface

// File: rtl/mm_digit_serial_mac.sv
// Digit-serial wide multiply: streams B one digit per cycle into an external
// A x digit multiplier and accumulates the shifted partial products.
module mm_digit_serial_mac #(
  parameter int A_W      = 149,
  parameter int D_W      = 16,
  parameter int NUM_DIG  = 9,
  parameter int MULT_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  mm_digit_serial_mac_if.slave bus
);
  localparam int B_W = NUM_DIG*D_W;
  localparam int R_W = A_W + B_W;
  localparam int K_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_DIG-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 start_acc;
  logic [A_W-1:0]       a_q;
  logic [B_W-1:0]       b_q;
  logic [R_W-1:0]       acc_q, result_q, term, acc_sum;
  logic                 busy_q, done_q;
  logic                 issue, acc_last;

  // Tag pipeline runs alongside the multiplier; stage MULT_LAT lines up with mult_p.
  logic [MULT_LAT:1]            vld_pipe;
  logic [MULT_LAT:1][K_W-1:0]   idx_pipe;

  assign issue    = (state_q == ISSUE);
  assign acc_last = vld_pipe[MULT_LAT] && (idx_pipe[MULT_LAT] == K_LAST);
  assign term     = R_W'(bus.mult_p) << (idx_pipe[MULT_LAT] * D_W);
  assign acc_sum  = acc_q + term;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        start_acc = 1'b1;
        state_d   = ISSUE;
        k_d       = '0;
      end
      ISSUE: begin
        if (k_q == K_LAST) state_d = DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      DRAIN: if (acc_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= 1'b0;
      if (start_acc) begin
        a_q    <= bus.a_in;
        b_q    <= bus.b_in;
        acc_q  <= '0;
        busy_q <= 1'b1;
      end else if (vld_pipe[MULT_LAT]) begin
        acc_q  <= acc_sum;
      end
      if (acc_last) begin
        done_q   <= 1'b1;
        result_q <= acc_sum;
        busy_q   <= 1'b0;
      end
      vld_pipe[1] <= issue;
      idx_pipe[1] <= k_q;
      for (int i = 2; i <= MULT_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.mult_a = a_q;
  assign bus.mult_b = issue ? b_q[k_q*D_W +: D_W] : '0;
endmodule
